subtrator_8_bits_seq: RTL and testbench

//  Block-serial 8-bit subtractor: vetr = vet1 - vet2 - bin. One LARG_BLOCO-bit slice per clock, LSB slice first.

---
 rtl/subtrator_pkg.sv | 26 ++
 rtl/subtrator_bloco.sv | 28 ++
 rtl/subtrator_8_bits_seq.sv | 171 +++++++++++++++++
 tb/tb_subtrator_8_bits_seq.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/subtrator_pkg.sv
// ----------------------------------------------------------------------------
// subtrator_pkg
//   Shared types and constants for the block-serial subtractor.
//   - state_t      : FSM states of the serial subtractor (IDLE, CALC, DONE)
//   - LARG_TOTAL_DEF / QTD_BLOCOS_DEF : default operand width / slice count
//   - cnt_width()  : width of a slice counter able to index n slices
// ----------------------------------------------------------------------------
package subtrator_pkg;

    localparam int LARG_TOTAL_DEF = 8;
    localparam int QTD_BLOCOS_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-slice configuration still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(QTD_BLOCOS_DEF);

endpackage

// File: rtl/subtrator_bloco.sv
// ----------------------------------------------------------------------------
// subtrator_bloco
//   Combinational W-bit slice subtractor: {bout, d} = a - b - bin.
//   Ports:
//     a    in  W   minuend slice
//     b    in  W   subtrahend slice
//     bin  in  1   borrow into the slice
//     d    out W   difference slice
//     bout out 1   borrow out of the slice
// ----------------------------------------------------------------------------
module subtrator_bloco #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] d,
    output logic         bout
);

    // One extra bit: a negative result sets the top bit, which is the borrow.
    logic [W:0] diff;

    assign diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
    assign d    = diff[W-1:0];
    assign bout = diff[W];

endmodule

// File: rtl/subtrator_8_bits_seq.sv
// ----------------------------------------------------------------------------
// subtrator_8_bits_seq
//   Block-serial subtractor: vetr = vet1 - vet2 - bin, one LARG_BLOCO-bit
//   slice per clock, LSB slice first, borrow registered between slices.
//   A single shared subtrator_bloco instance does all the slice work.
//
//   Ports:
//     clk    in   1           rising-edge clock
//     rst_n  in   1           synchronous active-low reset
//     start  in   1           request, accepted only while ready=1
//     vet1   in   LARG_TOTAL  minuend, sampled on accept
//     vet2   in   LARG_TOTAL  subtrahend, sampled on accept
//     bin    in   1           borrow-in, sampled on accept
//     ready  out  1           high in IDLE only
//     valid  out  1           result valid, held until ack
//     ack    in   1           result consumed (only meaningful while valid=1)
//     vetr   out  LARG_TOTAL  difference mod 2^LARG_TOTAL
//     bout   out  1           borrow-out (vet1 < vet2 + bin, unsigned)
//     ovf    out  1           signed overflow, present only with SUB_OVERFLOW_EN
//
//   Build option: define SUB_OVERFLOW_EN to add the ovf port and its logic.
//   QTD_BLOCOS must divide LARG_TOTAL; LARG_BLOCO is derived.
// ----------------------------------------------------------------------------
module subtrator_8_bits_seq
    import subtrator_pkg::*;
#(
    parameter  int LARG_TOTAL = LARG_TOTAL_DEF,
    parameter  int QTD_BLOCOS = QTD_BLOCOS_DEF,
    localparam int LARG_BLOCO = LARG_TOTAL / QTD_BLOCOS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LARG_TOTAL-1:0] vet1,
    input  logic [LARG_TOTAL-1:0] vet2,
    input  logic                  bin,
    output logic                  ready,
    output logic                  valid,
    input  logic                  ack,
    output logic [LARG_TOTAL-1:0] vetr,
    output logic                  bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic                  ovf
`endif
);

    localparam int CNT_W = cnt_width(QTD_BLOCOS);
    localparam int MSB   = LARG_TOTAL - 1;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    borrow_q, borrow_d;
    logic [LARG_TOTAL-1:0]   a_q, a_d;
    logic [LARG_TOTAL-1:0]   b_q, b_d;
    logic [LARG_TOTAL-1:0]   vetr_q, vetr_d;
    logic                    bout_q, bout_d;
`ifdef SUB_OVERFLOW_EN
    logic                    ovf_q, ovf_d;
`endif

    int                      off;
    logic [LARG_BLOCO-1:0]   sl_a, sl_b, sl_d;
    logic                    sl_bout;
    logic                    last_slice;

    // Bit offset of the slice currently being processed.
    always_comb begin
        off  = int'(cnt_q) * LARG_BLOCO;
        sl_a = a_q[off +: LARG_BLOCO];
        sl_b = b_q[off +: LARG_BLOCO];
    end

    assign last_slice = (cnt_q == CNT_W'(QTD_BLOCOS - 1));

    subtrator_bloco #(
        .W    (LARG_BLOCO)
    ) u_bloco (
        .a    (sl_a),
        .b    (sl_b),
        .bin  (borrow_q),
        .d    (sl_d),
        .bout (sl_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        a_d      = a_q;
        b_d      = b_q;
        vetr_d   = vetr_q;
        bout_d   = bout_q;
`ifdef SUB_OVERFLOW_EN
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = vet1;
                    b_d      = vet2;
                    borrow_d = bin;
                    cnt_d    = '0;
                    vetr_d   = '0;
                    bout_d   = 1'b0;
`ifdef SUB_OVERFLOW_EN
                    ovf_d    = 1'b0;
`endif
                    state_d  = CALC;
                end
            end
            CALC: begin
                vetr_d[off +: LARG_BLOCO] = sl_d;
                borrow_d = sl_bout;
                cnt_d    = cnt_q + 1'b1;
                if (last_slice) begin
                    bout_d  = sl_bout;
`ifdef SUB_OVERFLOW_EN
                    // The last slice holds the MSB, so sl_d's top bit is the
                    // result sign.
                    ovf_d   = (a_q[MSB] != b_q[MSB]) &&
                              (sl_d[LARG_BLOCO-1] != a_q[MSB]);
`endif
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            vetr_q   <= '0;
            bout_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            a_q      <= a_d;
            b_q      <= b_d;
            vetr_q   <= vetr_d;
            bout_q   <= bout_d;
`ifdef SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign ready = (state_q == IDLE);
    assign valid = (state_q == DONE);
    assign vetr  = vetr_q;
    assign bout  = bout_q;
`ifdef SUB_OVERFLOW_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_subtrator_8_bits_seq.sv
// ----------------------------------------------------------------------------
// tb_subtrator_8_bits_seq
//   Self-checking bench for subtrator_8_bits_seq (default 8-bit, 2 slices).
//   Inputs are driven and outputs sampled on the falling clock edge.
//   Define SUB_OVERFLOW_EN to also exercise the ovf output.
// ----------------------------------------------------------------------------
module tb_subtrator_8_bits_seq;

    typedef struct packed {
        logic [7:0] r;
        logic       bo;
        logic       ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] vet1, vet2;
    logic       bin;
    logic       ready, valid, ack;
    logic [7:0] vetr;
    logic       bout;
`ifdef SUB_OVERFLOW_EN
    logic       ovf;
`endif

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    subtrator_8_bits_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .vet1  (vet1),
        .vet2  (vet2),
        .bin   (bin),
        .ready (ready),
        .valid (valid),
        .ack   (ack),
        .vetr  (vetr),
        .bout  (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Reference: unsigned 9-bit difference, signed overflow from operand signs.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bi);
        logic [8:0] full;
        exp_t e;
        full = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        e.r  = full[7:0];
        e.bo = full[8];
        e.ov = (a[7] != b[7]) && (full[7] != a[7]);
        return e;
    endfunction

    // Called at a falling edge with ready=1; returns at the falling edge after accept.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bi);
        start = 1'b1; vet1 = a; vet2 = b; bin = bi;
        sb.push_back(model(a, b, bi));
        @(negedge clk);
        start = 1'b0;
        vet1  = 8'($urandom); vet2 = 8'($urandom); bin = 1'($urandom);
    endtask

    // Counts falling edges until valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ack = 1'b0;
        vet1 = 8'hA5; vet2 = 8'h5A; bin = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if (ready !== 1'b1 || valid !== 1'b0 || vetr !== 8'h00 || bout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: ready=%b valid=%b vetr=%h bout=%b, want 1 0 00 0", ready, valid, vetr, bout);
        end
`ifdef SUB_OVERFLOW_EN
        n_vec++;
        if (ovf !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ovf: ovf=%b want 0", ovf);
        end
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith(input string name, input logic [7:0] a, input logic [7:0] b, input logic bi);
        int   lat;
        exp_t e;
        issue(a, b, bi);
        wait_valid(lat);
        n_vec++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d cycles, want 2", name, lat);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            n_vec++;
            if (vetr !== e.r || bout !== e.bo) begin
                n_bad++;
                $display("FAIL %s: vetr=%h bout=%b, want vetr=%h bout=%b", name, vetr, bout, e.r, e.bo);
            end
`ifdef SUB_OVERFLOW_EN
            n_vec++;
            if (ovf !== e.ov) begin
                n_bad++;
                $display("FAIL %s_ovf: ovf=%b want %b", name, ovf, e.ov);
            end
`endif
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_vec++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_ack: ready=%b valid=%b, want 1 0", name, ready, valid);
        end
    endtask

    task automatic test_basic();
        test_arith("sub_5A_3C", 8'h5A, 8'h3C, 1'b0);
        test_arith("sub_10_20", 8'h10, 8'h20, 1'b0);
        test_arith("sub_00_00_b", 8'h00, 8'h00, 1'b1);
        test_arith("cross_slice", 8'h40, 8'h01, 1'b0);
        // Sanity on the reference itself for the documented vectors.
        n_vec++;
        if (model(8'h5A, 8'h3C, 1'b0) !== {8'h1E, 1'b0, 1'b0} ||
            model(8'h00, 8'h00, 1'b1) !== {8'hFF, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL model_table: reference disagrees with documented vectors");
        end
    endtask

`ifdef SUB_OVERFLOW_EN
    task automatic test_overflow();
        test_arith("ovf_80_01", 8'h80, 8'h01, 1'b0);
        test_arith("ovf_7F_FF", 8'h7F, 8'hFF, 1'b0);
        test_arith("ovf_05_03", 8'h05, 8'h03, 1'b0);
    endtask
`endif

    task automatic test_hold_ack();
        int   lat;
        exp_t e;
        issue(8'hC3, 8'h4D, 1'b1);
        wait_valid(lat);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        for (int i = 0; i < 10; i++) begin
            // Stray start pulses with different operands must be ignored.
            start = i[0]; vet1 = 8'($urandom); vet2 = 8'($urandom);
            @(negedge clk);
            n_vec++;
            if (valid !== 1'b1 || ready !== 1'b0 || vetr !== e.r || bout !== e.bo) begin
                n_bad++;
                $display("FAIL hold_%0d: valid=%b ready=%b vetr=%h bout=%b, want 1 0 %h %b",
                         i, valid, ready, vetr, bout, e.r, e.bo);
            end
        end
        start = 1'b0;
        ack   = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        n_vec++;
        if (ready !== 1'b1 || valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_release: ready=%b valid=%b, want 1 0", ready, valid);
        end
    endtask

    task automatic test_reset_mid_calc();
        issue(8'hFF, 8'h01, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ready !== 1'b1 || valid !== 1'b0 || vetr !== 8'h00 || bout !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: ready=%b valid=%b vetr=%h bout=%b, want 1 0 00 0", ready, valid, vetr, bout);
        end
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        n_vec++;
        if (valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_novalid: valid=%b want 0", valid);
        end
        test_arith("after_reset", 8'h5A, 8'h3C, 1'b0);
    endtask

    // Start held high with ack: next op is accepted on the first IDLE cycle.
    task automatic test_back_to_back();
        int         lat;
        exp_t       e;
        logic [7:0] a, b;
        logic       bi;
        a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
        issue(a, b, bi);
        for (int i = 0; i < 16; i++) begin
            wait_valid(lat);
            n_vec++;
            if (lat !== 2 || sb.size() == 0) begin
                n_bad++;
                $display("FAIL b2b_%0d_timing: latency=%0d queued=%0d, want 2 and 1", i, lat, sb.size());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                n_vec++;
                if (vetr !== e.r || bout !== e.bo) begin
                    n_bad++;
                    $display("FAIL b2b_%0d: vetr=%h bout=%b, want %h %b", i, vetr, bout, e.r, e.bo);
                end
            end
            if (i == 15) begin
                ack = 1'b1;
                @(negedge clk);
                ack = 1'b0;
            end else begin
                a = 8'($urandom); b = 8'($urandom); bi = 1'($urandom);
                ack = 1'b1; start = 1'b1; vet1 = a; vet2 = b; bin = bi;
                sb.push_back(model(a, b, bi));
                @(negedge clk);
                ack = 1'b0;
                n_vec++;
                if (ready !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_%0d_ready: ready=%b want 1", i, ready);
                end
                @(negedge clk);
                start = 1'b0;
                vet1 = 8'($urandom); vet2 = 8'($urandom); bin = 1'($urandom);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
`ifdef SUB_OVERFLOW_EN
        test_overflow();
`endif
        test_hold_ack();
        test_reset_mid_calc();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
